// File: rtl/dragonfang_pkg.sv
// Shared types for the dragonfang integer vector pipeline: mode encodings,
// the narrowing FSM state and small mode-decoding helpers.
package dragonfang_pkg;

  // Ratio between source and destination element width.
  typedef enum logic [1:0] {
    FRAC_HALF    = 2'd0,
    FRAC_QUARTER = 2'd1,
    FRAC_EIGHTH  = 2'd2
  } fraction_mode_t;

  // Destination element width (SEW).
  typedef enum logic [1:0] {
    BITS_8  = 2'd0,
    BITS_16 = 2'd1,
    BITS_32 = 2'd2
  } bit_mode_t;

  // How a wide element is reduced to the destination width.
  typedef enum logic [1:0] {
    NARROW_TRUNCATE     = 2'd0,
    NARROW_SAT_SIGNED   = 2'd1,
    NARROW_SAT_UNSIGNED = 2'd2
  } narrow_mode_t;

  // Narrowing unit control states.
  typedef enum logic [1:0] {
    NS_IDLE    = 2'd0,
    NS_COLLECT = 2'd1,
    NS_OUTPUT  = 2'd2
  } narrow_state_t;

  // Number of source beats per operation (R); undefined encodings map to 2.
  function automatic logic [3:0] ratio_of(input fraction_mode_t f);
    case (f)
      FRAC_QUARTER: ratio_of = 4'd4;
      FRAC_EIGHTH:  ratio_of = 4'd8;
      default:      ratio_of = 4'd2;
    endcase
  endfunction

  // Width of the vd slice written by one beat (64 / R).
  function automatic logic [6:0] slice_bits_of(input fraction_mode_t f);
    case (f)
      FRAC_QUARTER: slice_bits_of = 7'd16;
      FRAC_EIGHTH:  slice_bits_of = 7'd8;
      default:      slice_bits_of = 7'd32;
    endcase
  endfunction

  // Destination element width in bits; undefined encodings map to 8.
  function automatic int unsigned dest_bits_of(input bit_mode_t b);
    case (b)
      BITS_16: dest_bits_of = 16;
      BITS_32: dest_bits_of = 32;
      default: dest_bits_of = 8;
    endcase
  endfunction

  // A combination is legal only if the source element fits in 64 bits
  // and every encoding is defined.
  function automatic logic is_legal(input fraction_mode_t f, input bit_mode_t b,
                                    input narrow_mode_t n);
    logic ok;
    ok = 1'b0;
    case (f)
      FRAC_HALF:    ok = (b == BITS_8) || (b == BITS_16) || (b == BITS_32);
      FRAC_QUARTER: ok = (b == BITS_8) || (b == BITS_16);
      FRAC_EIGHTH:  ok = (b == BITS_8);
      default:      ok = 1'b0;
    endcase
    if (!((n == NARROW_TRUNCATE) || (n == NARROW_SAT_SIGNED) || (n == NARROW_SAT_UNSIGNED)))
      ok = 1'b0;
    is_legal = ok;
  endfunction

endpackage

// File: rtl/vector_narrowing_lane.sv
// Combinational narrowing of one 64-bit source word into a 64/R-bit slice.
// Source element i sits at i*S; its narrowed result lands at i*D in the slice.
module vector_narrowing_lane
  import dragonfang_pkg::*;
(
  input  logic [63:0]    i_word,
  input  fraction_mode_t i_fraction_mode,
  input  bit_mode_t      i_bit_mode,
  input  narrow_mode_t   i_narrow_mode,
  output logic [31:0]    o_slice,
  output logic           o_sat
);

  int unsigned w_d;
  int unsigned w_s;
  logic [63:0] w_mask_s;
  logic [63:0] w_mask_d;
  logic [63:0] w_src;
  logic [63:0] w_upper;
  logic [63:0] w_res;
  logic [31:0] w_acc;

  // Narrow every source element of the word and pack the results.
  always_comb begin
    w_d      = dest_bits_of(i_bit_mode);
    w_s      = w_d * 32'(ratio_of(i_fraction_mode));
    w_mask_s = (w_s >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w_s) - 64'd1);
    w_mask_d = (64'd1 << w_d) - 64'd1;
    w_src    = '0;
    w_upper  = '0;
    w_res    = '0;
    w_acc    = '0;
    o_sat    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (32'(i) * w_s < 64) begin
        w_src   = (i_word >> (32'(i) * w_s)) & w_mask_s;
        // Bits from the destination sign position upward must all equal
        // the source sign for a signed value to fit.
        w_upper = w_src >> (w_d - 1);
        w_res   = w_src & w_mask_d;
        case (i_narrow_mode)
          NARROW_SAT_SIGNED: begin
            if (((w_src >> (w_s - 1)) & 64'd1) != 64'd0) begin
              if (w_upper != (w_mask_s >> (w_d - 1))) begin
                w_res = 64'd1 << (w_d - 1);
                o_sat = 1'b1;
              end
            end else if (w_upper != 64'd0) begin
              w_res = (64'd1 << (w_d - 1)) - 64'd1;
              o_sat = 1'b1;
            end
          end
          NARROW_SAT_UNSIGNED: begin
            if ((w_src >> w_d) != 64'd0) begin
              w_res = w_mask_d;
              o_sat = 1'b1;
            end
          end
          default: ;
        endcase
        w_acc = w_acc | 32'(w_res << (32'(i) * w_d));
      end
    end
    o_slice = w_acc;
  end

endmodule

// File: rtl/vector_narrowing_unit.sv
// Multi-cycle narrowing unit: accepts an operation, collects R source beats,
// narrows each into its slice of vd and presents vd with a sticky vxsat.
//
// Handshakes: every channel transfers on the rising edge where valid and
// ready are both high. op_ready is high only in IDLE, in_ready only in
// COLLECT, out_valid only in OUTPUT; valid/ready in other states is ignored.
// out_valid, vd, vxsat and op_error hold steady until out_ready is seen.
module vector_narrowing_unit
  import dragonfang_pkg::*;
(
  input  logic           i_clock,
  input  logic           i_reset_n,
  input  logic           i_op_valid,
  output logic           o_op_ready,
  input  fraction_mode_t i_fraction_mode,
  input  bit_mode_t      i_bit_mode,
  input  narrow_mode_t   i_narrow_mode,
  input  logic           i_in_valid,
  output logic           o_in_ready,
  input  logic [63:0]    i_in_data,
  output logic           o_out_valid,
  input  logic           i_out_ready,
  output logic [63:0]    o_vd,
  output logic           o_vxsat,
  output logic           o_op_error,
  output narrow_state_t  o_state
);

  narrow_state_t  r_state;
  narrow_state_t  w_next_state;
  fraction_mode_t r_frac;
  bit_mode_t      r_bits;
  narrow_mode_t   r_narrow;
  logic [3:0]     r_k;
  logic [63:0]    r_vd;
  logic           r_vxsat;
  logic           r_err;
  logic [31:0]    w_slice;
  logic           w_lane_sat;
  logic           w_legal;
  logic           w_op_fire;
  logic           w_beat;
  logic           w_last_beat;

  assign w_legal     = is_legal(i_fraction_mode, i_bit_mode, i_narrow_mode);
  assign w_op_fire   = o_op_ready & i_op_valid;
  assign w_beat      = o_in_ready & i_in_valid;
  assign w_last_beat = (r_k + 4'd1) == ratio_of(r_frac);

  vector_narrowing_lane u_lane (
    .i_word          (i_in_data),
    .i_fraction_mode (r_frac),
    .i_bit_mode      (r_bits),
    .i_narrow_mode   (r_narrow),
    .o_slice         (w_slice),
    .o_sat           (w_lane_sat)
  );

  // State register.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) r_state <= NS_IDLE;
    else            r_state <= w_next_state;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next_state = r_state;
    o_op_ready   = 1'b0;
    o_in_ready   = 1'b0;
    o_out_valid  = 1'b0;
    case (r_state)
      NS_IDLE: begin
        o_op_ready = 1'b1;
        if (i_op_valid) w_next_state = w_legal ? NS_COLLECT : NS_OUTPUT;
      end
      NS_COLLECT: begin
        o_in_ready = 1'b1;
        if (i_in_valid && w_last_beat) w_next_state = NS_OUTPUT;
      end
      NS_OUTPUT: begin
        o_out_valid = 1'b1;
        if (i_out_ready) w_next_state = NS_IDLE;
      end
      default: w_next_state = NS_IDLE;
    endcase
  end

  // Mode latch, beat counter, slice placement and sticky flags.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_frac   <= FRAC_HALF;
      r_bits   <= BITS_8;
      r_narrow <= NARROW_TRUNCATE;
      r_k      <= 4'd0;
      r_vd     <= 64'd0;
      r_vxsat  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_op_fire) begin
        r_frac   <= i_fraction_mode;
        r_bits   <= i_bit_mode;
        r_narrow <= i_narrow_mode;
        r_k      <= 4'd0;
        r_vd     <= 64'd0;
        r_vxsat  <= 1'b0;
        r_err    <= ~w_legal;
      end
      if (w_beat) begin
        r_vd    <= r_vd | ({32'd0, w_slice} << (r_k * slice_bits_of(r_frac)));
        r_vxsat <= r_vxsat | w_lane_sat;
        r_k     <= r_k + 4'd1;
      end
      if (o_out_valid && i_out_ready) r_err <= 1'b0;
    end
  end

  assign o_vd       = r_vd;
  assign o_vxsat    = r_vxsat;
  assign o_op_error = r_err;
  assign o_state    = r_state;

endmodule

// File: tb/tb_vector_narrowing_unit.sv
// Directed bench for vector_narrowing_unit: a table of operations with
// hand-computed results, plus backpressure and mid-operation reset sequences.
module tb_vector_narrowing_unit;
  import dragonfang_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic           op_valid = 1'b0;
  logic           op_ready;
  fraction_mode_t fraction_mode = FRAC_HALF;
  bit_mode_t      bit_mode = BITS_8;
  narrow_mode_t   narrow_mode = NARROW_TRUNCATE;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [63:0]    in_data = 64'd0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [63:0]    vd;
  logic           vxsat;
  logic           op_error;
  narrow_state_t  state;

  vector_narrowing_unit dut (
    .i_clock         (clk),
    .i_reset_n       (reset_n),
    .i_op_valid      (op_valid),
    .o_op_ready      (op_ready),
    .i_fraction_mode (fraction_mode),
    .i_bit_mode      (bit_mode),
    .i_narrow_mode   (narrow_mode),
    .i_in_valid      (in_valid),
    .o_in_ready      (in_ready),
    .i_in_data       (in_data),
    .o_out_valid     (out_valid),
    .i_out_ready     (out_ready),
    .o_vd            (vd),
    .o_vxsat         (vxsat),
    .o_op_error      (op_error),
    .o_state         (state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    fraction_mode_t   frac;
    bit_mode_t        bits;
    narrow_mode_t     nm;
    int               nbeats;
    logic [7:0][63:0] beats;
    int               gap_after;
    int               gap_n;
    logic [63:0]      exp_vd;
    logic             exp_sat;
    logic             exp_err;
    int               exp_cycle;
  } vec_t;

  function automatic vec_t mk(input fraction_mode_t f, input bit_mode_t b, input narrow_mode_t n,
                              input int nb, input logic [63:0] evd, input logic esat,
                              input logic eerr, input int ecyc);
    vec_t v;
    v.frac = f; v.bits = b; v.nm = n; v.nbeats = nb;
    v.beats = '0; v.gap_after = -1; v.gap_n = 0;
    v.exp_vd = evd; v.exp_sat = esat; v.exp_err = eerr; v.exp_cycle = ecyc;
    return v;
  endfunction

  localparam int NV = 11;
  vec_t tv [NV];

  // ---------------- driver ----------------
  task automatic run_op(input vec_t v, input int idx);
    int cycle;
    int bi;
    int gap_left;
    logic saw_in_ready;
    logic drove;
    logic rdy;
    logic [63:0] exp_vd;
    exp_q.push_back(v.exp_vd);
    @(negedge clk);
    check($sformatf("v%0d_op_ready", idx), {63'd0, op_ready}, 64'd1);
    fraction_mode = v.frac;
    bit_mode      = v.bits;
    narrow_mode   = v.nm;
    op_valid      = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    cycle = 1; bi = 0; gap_left = 0; saw_in_ready = 1'b0;
    while (!out_valid && cycle < 60) begin
      rdy = in_ready;
      if (rdy) saw_in_ready = 1'b1;
      drove = (bi < v.nbeats) && (gap_left == 0);
      in_valid = drove;
      in_data  = drove ? v.beats[bi] : 64'hDEAD_BEEF_0BAD_F00D;
      @(negedge clk);
      if (drove && rdy) begin
        bi++;
        if (bi == v.gap_after) gap_left = v.gap_n;
      end else if (!drove && gap_left > 0) begin
        gap_left--;
      end
      cycle++;
    end
    in_valid = 1'b0;
    check($sformatf("v%0d_no_timeout", idx), {63'd0, out_valid}, 64'd1);
    check($sformatf("v%0d_latency", idx), 64'(cycle), 64'(v.exp_cycle));
    exp_vd = exp_q.pop_front();
    check($sformatf("v%0d_vd", idx), vd, exp_vd);
    check($sformatf("v%0d_vxsat", idx), {63'd0, vxsat}, {63'd0, v.exp_sat});
    check($sformatf("v%0d_op_error", idx), {63'd0, op_error}, {63'd0, v.exp_err});
    check($sformatf("v%0d_in_ready_out", idx), {63'd0, in_ready}, 64'd0);
    check($sformatf("v%0d_beats_used", idx), 64'(bi), v.exp_err ? 64'd0 : 64'(v.nbeats));
    if (v.exp_err)
      check($sformatf("v%0d_in_ready_seen", idx), {63'd0, saw_in_ready}, 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check($sformatf("v%0d_out_valid_clr", idx), {63'd0, out_valid}, 64'd0);
    check($sformatf("v%0d_op_ready_back", idx), {63'd0, op_ready}, 64'd1);
    check($sformatf("v%0d_op_error_clr", idx), {63'd0, op_error}, 64'd0);
    check($sformatf("v%0d_vd_kept", idx), vd, exp_vd);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [63:0] held_vd;
    int wait_cnt;

    tv[0] = mk(FRAC_HALF, BITS_32, NARROW_TRUNCATE, 2, 64'h0000_0005_8000_0002, 1'b0, 1'b0, 3);
    tv[0].beats[0] = 64'h0000_0001_8000_0002;
    tv[0].beats[1] = 64'hFFFF_FFFF_0000_0005;
    tv[1] = mk(FRAC_HALF, BITS_32, NARROW_SAT_SIGNED, 2, 64'h8000_0000_7FFF_FFFF, 1'b1, 1'b0, 3);
    tv[1].beats[0] = 64'h0000_0001_0000_0000;
    tv[1].beats[1] = 64'hFFFF_FFFF_0000_0000;
    // Illegal right after a saturating op: vxsat must be cleared.
    tv[2] = mk(FRAC_QUARTER, BITS_32, NARROW_TRUNCATE, 0, 64'd0, 1'b0, 1'b1, 1);
    tv[3] = mk(FRAC_EIGHTH, BITS_8, NARROW_TRUNCATE, 8, 64'h0807_0605_0403_0201, 1'b0, 1'b0, 11);
    for (int i = 0; i < 8; i++) tv[3].beats[i] = 64'(i + 1);
    tv[3].gap_after = 3;
    tv[3].gap_n = 2;
    tv[4] = mk(FRAC_QUARTER, BITS_8, NARROW_SAT_UNSIGNED, 4, 64'h0000_0000_0000_FFFF, 1'b1, 1'b0, 5);
    tv[4].beats[0] = 64'h0000_0100_0000_00FF;
    tv[5] = mk(FRAC_HALF, BITS_8, NARROW_SAT_SIGNED, 2, 64'h0001_FFFE_7F80_7F80, 1'b1, 1'b0, 3);
    tv[5].beats[0] = 64'h0080_FF80_007F_FF7F;
    tv[5].beats[1] = 64'h0000_0001_FFFF_FFFE;
    tv[6] = mk(FRAC_HALF, BITS_16, NARROW_TRUNCATE, 2, 64'hBBBB_DDDD_5678_DEF0, 1'b0, 1'b0, 3);
    tv[6].beats[0] = 64'h1234_5678_9ABC_DEF0;
    tv[6].beats[1] = 64'hAAAA_BBBB_CCCC_DDDD;
    tv[7] = mk(FRAC_QUARTER, BITS_16, NARROW_SAT_UNSIGNED, 4, 64'hFFFF_FFFF_FFFF_1234, 1'b1, 1'b0, 5);
    tv[7].beats[0] = 64'h0000_0000_0000_1234;
    tv[7].beats[1] = 64'h0000_0000_0001_0000;
    tv[7].beats[2] = 64'h8000_0000_0000_0000;
    tv[7].beats[3] = 64'h0000_0000_0000_FFFF;
    tv[8] = mk(FRAC_EIGHTH, BITS_8, NARROW_SAT_SIGNED, 8, 64'h0403_0201_0080_7FFB, 1'b0, 1'b0, 9);
    tv[8].beats[0] = 64'hFFFF_FFFF_FFFF_FFFB;
    tv[8].beats[1] = 64'h0000_0000_0000_007F;
    tv[8].beats[2] = 64'hFFFF_FFFF_FFFF_FF80;
    for (int i = 3; i < 8; i++) tv[8].beats[i] = 64'(i - 3);
    tv[9]  = mk(FRAC_EIGHTH, BITS_16, NARROW_TRUNCATE, 0, 64'd0, 1'b0, 1'b1, 1);
    tv[10] = mk(FRAC_HALF, BITS_8, narrow_mode_t'(2'd3), 0, 64'd0, 1'b0, 1'b1, 1);

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_op_ready", {63'd0, op_ready}, 64'd1);
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_vd", vd, 64'd0);
    check("rst_vxsat", {63'd0, vxsat}, 64'd0);
    check("rst_op_error", {63'd0, op_error}, 64'd0);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) run_op(tv[i], i);

    // Backpressure: outputs hold, op and in requests ignored.
    @(negedge clk);
    fraction_mode = FRAC_HALF; bit_mode = BITS_32; narrow_mode = NARROW_TRUNCATE;
    op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    in_valid = 1'b1; in_data = 64'h0000_0001_8000_0002;
    @(negedge clk);
    in_data = 64'hFFFF_FFFF_0000_0005;
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_out_valid", {63'd0, out_valid}, 64'd1);
    held_vd = 64'h0000_0005_8000_0002;
    check("bp_vd", vd, held_vd);
    for (int c = 0; c < 3; c++) begin
      op_valid = 1'b1; fraction_mode = FRAC_QUARTER; bit_mode = BITS_32;
      in_valid = 1'b1; in_data = 64'hFFFF_FFFF_FFFF_FFFF;
      @(negedge clk);
      check($sformatf("bp%0d_out_valid", c), {63'd0, out_valid}, 64'd1);
      check($sformatf("bp%0d_vd", c), vd, held_vd);
      check($sformatf("bp%0d_op_ready", c), {63'd0, op_ready}, 64'd0);
      check($sformatf("bp%0d_op_error", c), {63'd0, op_error}, 64'd0);
    end
    op_valid = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_released", {63'd0, out_valid}, 64'd0);

    // Reset pulse in the middle of COLLECT discards the partial result.
    fraction_mode = FRAC_QUARTER; bit_mode = BITS_8; narrow_mode = NARROW_SAT_UNSIGNED;
    op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    in_valid = 1'b1; in_data = 64'h0000_0100_0000_00FF;
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_state_collect", 64'(state), 64'(NS_COLLECT));
    check("mid_vxsat", {63'd0, vxsat}, 64'd1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("rp_out_valid", {63'd0, out_valid}, 64'd0);
    check("rp_op_ready", {63'd0, op_ready}, 64'd1);
    check("rp_in_ready", {63'd0, in_ready}, 64'd0);
    check("rp_vd", vd, 64'd0);
    check("rp_vxsat", {63'd0, vxsat}, 64'd0);
    check("rp_state", 64'(state), 64'(NS_IDLE));
    wait_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; in_data = 64'h0123_4567_89AB_CDEF;
      @(negedge clk);
      if (out_valid || !op_ready) wait_cnt++;
    end
    in_valid = 1'b0;
    check("rp_no_stale_output", 64'(wait_cnt), 64'd0);

    // Unit recovers fully after the reset pulse.
    run_op(tv[6], 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    failures++;
    $display("FAIL global_timeout actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
